mips_mem_arbiter: RTL
=====================

# mips_mem_arbiter

Sequences a single-ported, fixed-latency unified memory between the pipelined MIPS core's instruction-fetch (IF) and data (MEM stage load/store) ports. Data accesses have priority, fetch is protected from starvation, and per-port stall signals are generated for the pipeline hazard logic. Sits between `processor` and the shared memory model, replacing separate instruction and data memories.

## Interface
- `MEM_LAT`, 2: cycles from the `mem_en` cycle to valid `mem_rdata`; legal range 1..15.
- `STARVE_MAX`, 4: consecutive data grants allowed while a fetch is pending; legal range 1..15.
- `clock` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `if_req` in 1: fetch request; level, held until `if_ready`.
- `if_addr` in 32: fetch byte address (PC).
- `if_rdata` out 32: fetched instruction; valid while `if_ready` is high.
- `if_ready` out 1: one-cycle completion pulse for fetch.
- `d_rd` in 1: load request; level, held until `d_ready`.
- `d_wr` in 1: store request; level, held until `d_ready`.
- `d_addr` in 32: data byte address.
- `d_wdata` in 32: store data.
- `d_rdata` out 32: load data; valid while `d_ready` is high.
- `d_ready` out 1: one-cycle completion pulse for load or store.
- `mem_en` out 1: memory access strobe; one cycle per access.
- `mem_we` out 1: write enable; qualified by `mem_en`.
- `mem_addr` out 30: word address, equal to byte address [31:2].
- `mem_wdata` out 32: write data.
- `mem_rdata` in 32: read data, valid exactly `MEM_LAT` cycles after the `mem_en` cycle.
- `stall_if` out 1: `if_req & ~if_ready`.
- `stall_mem` out 1: `(d_rd | d_wr) & ~d_ready`.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. Registered owner bit: IF or DATA.
- IDLE: at the clock edge with any request, select a winner, latch its address, write data and write flag, then move to ISSUE. With no request, stay in IDLE.
- Priority: DATA wins over IF. Exception: when `starve_cnt == STARVE_MAX` and `if_req` is high, IF wins.
- `starve_cnt` (4 bits):
  - Increments on each DATA grant made while `if_req` is high.
  - Clears on an IF grant.
  - Clears on a DATA grant made with `if_req` low.
  - Saturates at `STARVE_MAX`.
- ISSUE: `mem_en=1`. `mem_we=1` only for a DATA store. Load `lat_cnt=MEM_LAT`, then go to WAIT.
- WAIT: decrement `lat_cnt` each cycle. In the cycle where `lat_cnt==1`, capture `mem_rdata` into the owner's rdata register and go to RESP.
- RESP: pulse the owner's ready for one cycle and return to IDLE. No grant is made in RESP, so a request still high during the ready cycle is not re-granted.
- `d_rd` and `d_wr` both high: treated as a store.
- Address, data and request changes after the grant are ignored (values are latched). A request dropped mid-transaction still completes, and ready still pulses.
- `d_rdata` after a store: unchanged from its previous value.
- `if_rdata` and `d_rdata` hold their last captured value outside ready cycles.

## Timing
- Request sampled at edge E0. `mem_en` is high in cycle E0+1. Data is captured at the end of cycle E0+1+`MEM_LAT`. Ready is high in cycle E0+2+`MEM_LAT`.
- Request-to-ready latency: `MEM_LAT+2` cycles.
- Back-to-back throughput: one access per `MEM_LAT+3` cycles.
- All outputs are registered, except `stall_if` and `stall_mem`, which are combinational from request and ready.
- Reset values: FSM=IDLE, `starve_cnt=0`, `lat_cnt=0`, and `mem_en`, `mem_we`, `if_ready`, `d_ready` all 0. `mem_addr`, `mem_wdata`, `if_rdata` and `d_rdata` are all 0.
- Reset mid-transaction: abandon the access immediately and issue no ready pulse. A write already strobed to memory is not undone.
- Simultaneous `if_req` and data request in IDLE: DATA granted, subject to the starvation rule. IF waits with `stall_if` high.

## Structure
- Shared package `mips_mem_pkg` contains:
  - FSM state typedef/constants: IDLE, ISSUE, WAIT, RESP.
  - Owner encoding: OWN_IF=0, OWN_DATA=1.
  - Word-address width constant `MEM_AW=30`.
- The block is a single module with no sub-module; the arbitration decision and the two counters are small enough to stay inline.

## Test plan
All scenarios use `MEM_LAT=2`, `STARVE_MAX=4`, with a memory model of fixed latency 2.
- Single fetch: `if_req` with `if_addr=0x8`, memory word 2 = 0x20030007. Expect `mem_en` at E0+1 with `mem_addr=2`, `if_ready` at E0+4, and `if_rdata=0x20030007`.
- Store then load: `d_wr` with `d_addr=0x8`, `d_wdata=0x5A`. Expect `mem_we=1` and `d_ready` at E0+4. A following `d_rd` to 0x8 returns `d_rdata=0x5A`.
- Contention: `if_req` and `d_rd` high in the same cycle. Expect DATA served first, `stall_if` high for 9 cycles, and IF `mem_en` 5 cycles after DATA `mem_en`.
- Starvation: `d_rd` held continuously with `if_req` high. Expect exactly 4 DATA grants, then 1 IF grant, then DATA again.
- Reset mid-operation: assert `reset` in the WAIT cycle of a load. Expect no `d_ready`, all outputs 0, and the next request after reset served with normal latency.
- Both `d_rd` and `d_wr` high with `d_addr=0x4`, `d_wdata=0x11`. Expect a write with `mem_we=1`, memory word 1 = 0x11, and `d_rdata` unchanged.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: shared types for the IF/MEM unified memory arbiter.
// FSM states, owner encoding and word-address width.
package mips_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic OWN_IF   = 1'b0;
  localparam logic OWN_DATA = 1'b1;

  localparam int MEM_AW = 30;

endpackage

// File: rtl/mips_mem_arbiter.sv
// mips_mem_arbiter: shares one fixed-latency memory between the
// IF port and the MEM-stage data port; data first, IF anti-starve.
// Ports: clock/reset; if_req/if_addr -> if_rdata/if_ready;
//   d_rd/d_wr/d_addr/d_wdata -> d_rdata/d_ready;
//   mem_en/mem_we/mem_addr/mem_wdata, mem_rdata;
//   stall_if/stall_mem for the hazard unit.
module mips_mem_arbiter
  import mips_mem_pkg::*;
#(
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_ready,
  input  logic              d_rd,
  input  logic              d_wr,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic [31:0]       d_rdata,
  output logic              d_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              stall_if,
  output logic              stall_mem
);

  localparam logic [3:0] LAT_INIT   = 4'(MEM_LAT);
  localparam logic [3:0] STARVE_TOP = 4'(STARVE_MAX);

  state_t state_q, state_d;
  logic owner_q, owner_d;
  logic we_q, we_d;
  logic [3:0] lat_cnt_q, lat_cnt_d;
  logic [3:0] starve_cnt_q, starve_cnt_d;
  logic mem_en_q, mem_en_d;
  logic mem_we_q, mem_we_d;
  logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic if_ready_q, if_ready_d;
  logic d_ready_q, d_ready_d;

  logic d_req;
  logic if_win;
  logic unused_byte_bits;

  assign d_req = d_rd | d_wr;
  // IF only beats a data request once data has had its run.
  assign if_win = if_req &
    (~d_req | (starve_cnt_q == STARVE_TOP));
  assign unused_byte_bits = ^{if_addr[1:0], d_addr[1:0]};

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    we_d         = we_q;
    lat_cnt_d    = lat_cnt_q;
    starve_cnt_d = starve_cnt_q;
    mem_en_d     = 1'b0;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    if_rdata_d   = if_rdata_q;
    d_rdata_d    = d_rdata_q;
    if_ready_d   = 1'b0;
    d_ready_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (if_req | d_req) begin
          state_d  = ISSUE;
          mem_en_d = 1'b1;
          if (if_win) begin
            owner_d      = OWN_IF;
            we_d         = 1'b0;
            mem_addr_d   = if_addr[31:2];
            starve_cnt_d = 4'd0;
          end else begin
            owner_d     = OWN_DATA;
            we_d        = d_wr;
            mem_we_d    = d_wr;
            mem_addr_d  = d_addr[31:2];
            mem_wdata_d = d_wdata;
            if (!if_req)
              starve_cnt_d = 4'd0;
            else if (starve_cnt_q != STARVE_TOP)
              starve_cnt_d = starve_cnt_q + 4'd1;
          end
        end
      end
      ISSUE: begin
        lat_cnt_d = LAT_INIT;
        state_d   = WAIT;
      end
      WAIT: begin
        lat_cnt_d = lat_cnt_q - 4'd1;
        if (lat_cnt_q == 4'd1) begin
          state_d = RESP;
          if (owner_q == OWN_IF) begin
            if_rdata_d = mem_rdata;
            if_ready_d = 1'b1;
          end else begin
            // a store leaves the load data register alone
            if (!we_q)
              d_rdata_d = mem_rdata;
            d_ready_d = 1'b1;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      owner_q      <= OWN_IF;
      we_q         <= 1'b0;
      lat_cnt_q    <= 4'd0;
      starve_cnt_q <= 4'd0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= 32'd0;
      if_rdata_q   <= 32'd0;
      d_rdata_q    <= 32'd0;
      if_ready_q   <= 1'b0;
      d_ready_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      we_q         <= we_d;
      lat_cnt_q    <= lat_cnt_d;
      starve_cnt_q <= starve_cnt_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
      if_ready_q   <= if_ready_d;
      d_ready_q    <= d_ready_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign if_ready  = if_ready_q;
  assign d_rdata   = d_rdata_q;
  assign d_ready   = d_ready_q;

  assign stall_if  = if_req & ~if_ready_q;
  assign stall_mem = d_req & ~d_ready_q;

endmodule
